// File: rtl/requant_gain_ctrl_pkg.sv
// Shared types and default dimensions for the requant gain controller.
// The state encoding is visible to the host through state_out.
package requant_pkg;

  localparam int N_CHAN_DEF = 2048;
  localparam int ADDR_W_DEF = 11;
  localparam int GAIN_W_DEF = 5;
  localparam int OVF_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } state_e;

endpackage

// File: rtl/requant_gain_ctrl_gain_ram.sv
// Simple dual-port gain table: one write port and one registered read port.
// Both banks live in a single array; the bank is the address MSB.
module gain_ram
  import requant_pkg::*;
#(
  parameter int DEPTH = 2 * N_CHAN_DEF,
  parameter int AW    = ADDR_W_DEF + 1,
  parameter int DW    = GAIN_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the output register resets.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/requant_gain_ctrl.sv
// Requant sequencer: arms requant, tracks its progress, serves per-channel gains
// from a double-buffered table and counts overflows per spectrum.
module requant_gain_ctrl
  import requant_pkg::*;
#(
  parameter int N_CHAN = N_CHAN_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int OVF_W  = OVF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  output logic              arm_out,
  input  logic              rq_sync_out,
  input  logic [ADDR_W-1:0] rq_addr,
  input  logic              rq_overflow,
  output logic [GAIN_W-1:0] gain_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [GAIN_W-1:0] wr_gain,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              active_bank,
  output logic [1:0]        state_out,
  output logic [OVF_W-1:0]  ovf_count,
  output logic              ovf_valid
);

  state_e             state_q, state_d;
  logic               arm_q;
  logic               pending_q, pending_d;
  logic               bank_q, bank_d;
  logic [OVF_W-1:0]   acc_q, acc_d;
  logic [OVF_W-1:0]   ovf_count_q, ovf_count_d;
  logic               ovf_valid_q, ovf_valid_d;
  logic               boundary;
  logic               running_ce;
  logic [OVF_W-1:0]   acc_inc;
  logic               wr_en;

  assign running_ce = (state_q == RUNNING) && ce;
  assign boundary   = running_ce && (rq_addr == ADDR_W'(N_CHAN - 1));
  assign acc_inc    = (acc_q == '1) ? acc_q : acc_q + OVF_W'(rq_overflow);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ARMED;
    end else if (ce && (state_q == ARMED) && rq_sync_out) begin
      state_d = RUNNING;
    end
  end

  // Outside RUNNING the table is not being consumed, so a swap takes effect at once.
  always_comb begin
    pending_d = pending_q;
    bank_d    = bank_q;
    if (pending_q) begin
      if ((state_q != RUNNING) || boundary) begin
        bank_d    = ~bank_q;
        pending_d = 1'b0;
      end
    end else if (swap_req) begin
      if (state_q == RUNNING) begin
        pending_d = 1'b1;
      end else begin
        bank_d = ~bank_q;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_count_d = ovf_count_q;
    ovf_valid_d = 1'b0;
    if (boundary) begin
      ovf_count_d = acc_inc;
      ovf_valid_d = 1'b1;
      acc_d       = '0;
    end else if (running_ce) begin
      acc_d = acc_inc;
    end
    // A re-arm abandons the partial spectrum without reporting it.
    if ((state_q == RUNNING) && (state_d != RUNNING)) begin
      acc_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      pending_q   <= 1'b0;
      bank_q      <= 1'b0;
      acc_q       <= '0;
      ovf_count_q <= '0;
      ovf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= start;
      pending_q   <= pending_d;
      bank_q      <= bank_d;
      acc_q       <= acc_d;
      ovf_count_q <= ovf_count_d;
      ovf_valid_q <= ovf_valid_d;
    end
  end

  assign wr_en = wr_valid && !pending_q;

  gain_ram #(
    .DEPTH (2 * N_CHAN),
    .AW    (ADDR_W + 1),
    .DW    (GAIN_W)
  ) u_gain_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({~bank_q, wr_addr}),
    .wdata (wr_gain),
    .raddr ({bank_q, rq_addr}),
    .rdata (gain_out)
  );

  assign arm_out      = arm_q;
  assign wr_ready     = ~pending_q;
  assign swap_pending = pending_q;
  assign active_bank  = bank_q;
  assign state_out    = state_q;
  assign ovf_count    = ovf_count_q;
  assign ovf_valid    = ovf_valid_q;

endmodule

// File: tb/tb_requant_gain_ctrl.sv
// Directed bench for requant_gain_ctrl: FSM vector table plus hand-written
// sequences for bank swaps, overflow counting, saturation and reset.
module tb_requant_gain_ctrl;

  localparam int ADDR_W = 11;
  localparam int GAIN_W = 5;
  localparam int OVF_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic              start;
  logic              arm_out;
  logic              rq_sync_out;
  logic [ADDR_W-1:0] rq_addr;
  logic              rq_overflow;
  logic [GAIN_W-1:0] gain_out;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [GAIN_W-1:0] wr_gain;
  logic              swap_req;
  logic              swap_pending;
  logic              active_bank;
  logic [1:0]        state_out;
  logic [OVF_W-1:0]  ovf_count;
  logic              ovf_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       ce;
    logic       sync;
    logic [1:0] exp_state;
    logic       exp_arm;
  } fsm_vec_t;

  fsm_vec_t vecs [9];

  always #5 clk = ~clk;

  requant_gain_ctrl #(
    .N_CHAN (2048),
    .ADDR_W (ADDR_W),
    .GAIN_W (GAIN_W),
    .OVF_W  (OVF_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .start        (start),
    .arm_out      (arm_out),
    .rq_sync_out  (rq_sync_out),
    .rq_addr      (rq_addr),
    .rq_overflow  (rq_overflow),
    .gain_out     (gain_out),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_gain      (wr_gain),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .active_bank  (active_bank),
    .state_out    (state_out),
    .ovf_count    (ovf_count),
    .ovf_valid    (ovf_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_gain(input int addr, input int gain);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(addr);
    wr_gain  = GAIN_W'(gain);
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{start: 1'b1, ce: 1'b1, sync: 1'b0, exp_state: 2'd1, exp_arm: 1'b1};
    vecs[1] = '{start: 1'b0, ce: 1'b1, sync: 1'b0, exp_state: 2'd1, exp_arm: 1'b0};
    vecs[2] = '{start: 1'b0, ce: 1'b1, sync: 1'b0, exp_state: 2'd1, exp_arm: 1'b0};
    vecs[3] = '{start: 1'b0, ce: 1'b0, sync: 1'b1, exp_state: 2'd1, exp_arm: 1'b0};
    vecs[4] = '{start: 1'b0, ce: 1'b1, sync: 1'b1, exp_state: 2'd2, exp_arm: 1'b0};
    vecs[5] = '{start: 1'b0, ce: 1'b1, sync: 1'b0, exp_state: 2'd2, exp_arm: 1'b0};
    vecs[6] = '{start: 1'b1, ce: 1'b1, sync: 1'b0, exp_state: 2'd1, exp_arm: 1'b1};
    vecs[7] = '{start: 1'b0, ce: 1'b1, sync: 1'b0, exp_state: 2'd1, exp_arm: 1'b0};
    vecs[8] = '{start: 1'b0, ce: 1'b1, sync: 1'b1, exp_state: 2'd2, exp_arm: 1'b0};

    rst = 1'b0; ce = 1'b0; start = 1'b0; rq_sync_out = 1'b0; rq_addr = '0;
    rq_overflow = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_gain = '0; swap_req = 1'b0;
    repeat (3) tick();
    check("reset_gain_out", 32'(gain_out), 0);
    rst = 1'b1;
    ce  = 1'b1;
    tick();
    check("reset_state", 32'(state_out), 0);
    check("reset_arm", 32'(arm_out), 0);
    check("reset_bank", 32'(active_bank), 0);
    check("reset_pending", 32'(swap_pending), 0);
    check("reset_wr_ready", 32'(wr_ready), 1);
    check("reset_ovf_count", 32'(ovf_count), 0);
    check("reset_ovf_valid", 32'(ovf_valid), 0);

    // Fill bank 1 while bank 0 is active; the last write shares its cycle with swap_req.
    write_gain(7, 'h1A);
    write_gain(2047, 'h0B);
    wr_valid = 1'b1; wr_addr = '0; wr_gain = 5'h0C; swap_req = 1'b1;
    tick();
    wr_valid = 1'b0; swap_req = 1'b0;
    check("idle_swap_bank", 32'(active_bank), 1);
    check("idle_swap_pending", 32'(swap_pending), 0);
    write_gain(7, 'h03);
    write_gain(2047, 'h11);
    write_gain(0, 'h12);
    rq_addr = 11'd7;
    tick();
    check("gain_b1_ch7", 32'(gain_out), 'h1A);
    rq_addr = 11'd0;
    tick();
    check("gain_b1_ch0_same_cycle_wr", 32'(gain_out), 'h0C);

    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start; ce = vecs[i].ce; rq_sync_out = vecs[i].sync;
      tick();
      check($sformatf("fsm_state[%0d]", i), 32'(state_out), 32'(vecs[i].exp_state));
      check($sformatf("fsm_arm[%0d]", i), 32'(arm_out), 32'(vecs[i].exp_arm));
    end
    start = 1'b0; ce = 1'b1; rq_sync_out = 1'b0;

    // Swap while RUNNING waits for the spectrum boundary.
    rq_addr = 11'd100; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("run_swap_pending", 32'(swap_pending), 1);
    check("run_swap_wr_ready", 32'(wr_ready), 0);
    check("run_swap_bank_held", 32'(active_bank), 1);
    wr_valid = 1'b1; wr_addr = 11'd7; wr_gain = 5'h1F; rq_addr = 11'd101;
    tick();
    wr_valid = 1'b0;
    swap_req = 1'b1; rq_addr = 11'd2046;
    tick();
    swap_req = 1'b0;
    check("repeat_swap_ignored", 32'(active_bank), 1);
    ce = 1'b0; rq_addr = 11'd2047;
    tick();
    check("ce_low_no_boundary_pending", 32'(swap_pending), 1);
    check("ce_low_no_boundary_bank", 32'(active_bank), 1);
    ce = 1'b1;
    tick();
    check("boundary_bank", 32'(active_bank), 0);
    check("boundary_pending", 32'(swap_pending), 0);
    check("boundary_wr_ready", 32'(wr_ready), 1);
    check("boundary_gain_old_bank", 32'(gain_out), 'h0B);
    check("boundary0_ovf_valid", 32'(ovf_valid), 1);
    check("boundary0_ovf_count", 32'(ovf_count), 0);
    rq_addr = 11'd0;
    tick();
    check("gain_new_bank_ch0", 32'(gain_out), 'h12);
    check("ovf_valid_one_cycle", 32'(ovf_valid), 0);
    rq_addr = 11'd7;
    tick();
    check("blocked_write_kept", 32'(gain_out), 'h03);

    // Three counted overflows, one at ch2047; the ce-low one is ignored.
    rq_addr = 11'd5;  rq_overflow = 1'b1; tick();
    rq_addr = 11'd6;  rq_overflow = 1'b0; tick();
    rq_addr = 11'd10; rq_overflow = 1'b1; tick();
    ce = 1'b0; rq_addr = 11'd11; tick();
    ce = 1'b1; rq_addr = 11'd2047; tick();
    check("ovf3_valid", 32'(ovf_valid), 1);
    check("ovf3_count", 32'(ovf_count), 3);
    rq_overflow = 1'b0; rq_addr = 11'd0;
    tick();
    check("ovf3_valid_drop", 32'(ovf_valid), 0);
    check("ovf3_count_hold", 32'(ovf_count), 3);

    // Re-arm with a swap pending: swap completes the next cycle, partial count dropped.
    swap_req = 1'b1; rq_overflow = 1'b1;
    tick();
    swap_req = 1'b0; rq_overflow = 1'b0;
    check("rearm_pending_set", 32'(swap_pending), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rearm_state", 32'(state_out), 1);
    check("rearm_arm", 32'(arm_out), 1);
    check("rearm_still_pending", 32'(swap_pending), 1);
    check("rearm_bank_held", 32'(active_bank), 0);
    tick();
    check("rearm_swap_bank", 32'(active_bank), 1);
    check("rearm_swap_cleared", 32'(swap_pending), 0);
    check("rearm_arm_drop", 32'(arm_out), 0);
    rq_sync_out = 1'b1;
    tick();
    rq_sync_out = 1'b0;
    check("rerun_state", 32'(state_out), 2);
    rq_addr = 11'd3; rq_overflow = 1'b1; tick();
    rq_addr = 11'd2047; rq_overflow = 1'b0; tick();
    check("rearm_acc_cleared", 32'(ovf_count), 1);
    check("rearm_ovf_valid", 32'(ovf_valid), 1);

    // Saturation: overflow on every ce cycle for longer than the counter range.
    rq_addr = 11'd0; rq_overflow = 1'b1;
    repeat (65600) tick();
    rq_addr = 11'd2047;
    tick();
    check("sat_count", 32'(ovf_count), 'hFFFF);
    check("sat_valid", 32'(ovf_valid), 1);
    rq_overflow = 1'b0; rq_addr = 11'd0;
    tick();
    check("sat_state_running", 32'(state_out), 2);

    // Reset while RUNNING with bank 1 active; start in the same cycle must not arm.
    rst = 1'b0; start = 1'b1;
    tick();
    check("midreset_state", 32'(state_out), 0);
    check("midreset_bank", 32'(active_bank), 0);
    check("midreset_ovf_count", 32'(ovf_count), 0);
    check("midreset_arm", 32'(arm_out), 0);
    check("midreset_gain_out", 32'(gain_out), 0);
    rst = 1'b1; start = 1'b0;
    tick();
    check("post_reset_state", 32'(state_out), 0);
    check("post_reset_arm", 32'(arm_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
